// File: rtl/ppm_to_pwm_converter_if.sv
// PPM input / PWM output signal bundle for ppm_to_pwm_converter.
// The master side drives the PPM pulse train and its frame clock. The slave side drives the regenerated PWM.
interface ppm_to_pwm_converter_if;
  logic PPMSIG;
  logic ClkSlowPPM;
  logic PWMSIG;
  logic ClkSlowPWM;
  logic NoPulse;
  logic Saturated;

  modport master (
    output PPMSIG, ClkSlowPPM,
    input  PWMSIG, ClkSlowPWM, NoPulse, Saturated
  );

  modport slave (
    input  PPMSIG, ClkSlowPPM,
    output PWMSIG, ClkSlowPWM, NoPulse, Saturated
  );
endinterface

// File: rtl/ppm_to_pwm_converter.sv
// Rebuilds a PWM waveform from a PPM pulse train and its frame clock.
// The pulse position measured in frame N-1 is replayed as the PWM high time of frame N.
module ppm_to_pwm_converter #(
  parameter int CNT_W = 16
) (
  input logic                   ClkFast,
  input logic                   Reset,
  ppm_to_pwm_converter_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // [0]=s1, [1]=s2, [2]=s3 (edge-detect delay)
  logic [2:0]       ppm_sync, clk_sync;
  logic             frame_edge, pulse_edge;
  logic [CNT_W-1:0] pos_cnt, pos_nxt;
  logic [CNT_W-1:0] cap_width, out_width, out_nxt, remain;
  logic             captured, no_pulse, pwm, clk_pwm, saturated;

  always_ff @(posedge ClkFast or posedge Reset) begin
    if (Reset) begin
      ppm_sync <= '0;
      clk_sync <= '0;
    end else begin
      ppm_sync <= {ppm_sync[1:0], bus.PPMSIG};
      clk_sync <= {clk_sync[1:0], bus.ClkSlowPPM};
    end
  end

  assign frame_edge = clk_sync[1] & ~clk_sync[2];
  assign pulse_edge = ppm_sync[1] & ~ppm_sync[2];

  // pos_nxt is the position of the current cycle. A pulse d cycles after the
  // frame edge therefore measures d, and a coincident pulse measures 0.
  always_comb begin
    pos_nxt = pos_cnt;
    if (frame_edge)              pos_nxt = '0;
    else if (pos_cnt != CNT_MAX) pos_nxt = pos_cnt + CNT_ONE;
  end

  // Width that takes effect at this frame edge. The old capture is used even when
  // a pulse coincides with the edge.
  assign out_nxt = captured ? cap_width : out_width;

  always_ff @(posedge ClkFast or posedge Reset) begin
    if (Reset) begin
      pos_cnt   <= '0;
      saturated <= 1'b0;
      cap_width <= '0;
      captured  <= 1'b0;
      out_width <= '0;
      no_pulse  <= 1'b1;
    end else begin
      pos_cnt <= pos_nxt;
      if (!frame_edge && pos_cnt == CNT_MAX) saturated <= 1'b1;

      if (frame_edge) begin
        out_width <= out_nxt;
        no_pulse  <= ~captured;
      end

      // The first pulse of a frame wins. A pulse on the edge cycle opens the new frame.
      if (pulse_edge && (frame_edge || !captured)) begin
        cap_width <= pos_nxt;
        captured  <= 1'b1;
      end else if (frame_edge) begin
        captured  <= 1'b0;
      end
    end
  end

  // Replay: high for exactly out_nxt cycles. A reload while still high keeps the
  // output high, so 100% duty has no gap.
  always_ff @(posedge ClkFast or posedge Reset) begin
    if (Reset) begin
      remain  <= '0;
      pwm     <= 1'b0;
      clk_pwm <= 1'b0;
    end else begin
      if (frame_edge) begin
        remain <= out_nxt;
        pwm    <= (out_nxt != '0);
      end else begin
        if (remain != '0) remain <= remain - CNT_ONE;
        pwm <= (remain > CNT_ONE);
      end
      // Holds the same value as clk_s3, but from its own output flop.
      // Its rise lands with the first PWM high cycle.
      clk_pwm <= clk_sync[1];
    end
  end

  assign bus.PWMSIG     = pwm;
  assign bus.ClkSlowPWM = clk_pwm;
  assign bus.NoPulse    = no_pulse;
  assign bus.Saturated  = saturated;

endmodule

// File: tb/tb_ppm_to_pwm_converter.sv
// Directed bench for ppm_to_pwm_converter: a frame table for CNT_W=16,
// plus saturation and async-reset sequences on a CNT_W=4 instance.
module tb_ppm_to_pwm_converter;

  logic ClkFast = 1'b0;
  logic Reset   = 1'b0;
  always #5 ClkFast = ~ClkFast;

  ppm_to_pwm_converter_if bus ();
  ppm_to_pwm_converter_if bus_s ();

  ppm_to_pwm_converter #(.CNT_W(16)) dut (
    .ClkFast (ClkFast),
    .Reset   (Reset),
    .bus     (bus)
  );

  ppm_to_pwm_converter #(.CNT_W(4)) dut_s (
    .ClkFast (ClkFast),
    .Reset   (Reset),
    .bus     (bus_s)
  );

  typedef struct {
    int period;
    int off1;
    int off2;
    int exp_w;
    bit exp_np;
  } vec_t;

  typedef struct {
    int w;
    bit np;
    bit first_hi;
    bit glitch;
  } ofr_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input bit c, input bit p);
    bus.ClkSlowPPM   = c;
    bus.PPMSIG       = p;
    bus_s.ClkSlowPPM = c;
    bus_s.PPMSIG     = p;
  endtask

  // One input frame. The frame clock is high for the first half, and each PPM pulse lasts one cycle.
  task automatic run_frame(input int period, input int off1, input int off2);
    for (int c = 0; c < period; c++) begin
      @(posedge ClkFast); #1;
      set_in(c < period / 2, (c == off1) || (c == off2));
    end
  endtask

  // Output frame monitor: one record per ClkSlowPWM period.
  ofr_t q0[$];
  ofr_t q1[$];
  ofr_t cur[2];
  bit   open_f[2];
  bit   prev_c[2];
  bit   fell[2];

  initial begin
    forever begin
      @(negedge ClkFast);
      for (int i = 0; i < 2; i++) begin
        logic c, p, np;
        c  = (i == 1) ? bus_s.ClkSlowPWM : bus.ClkSlowPWM;
        p  = (i == 1) ? bus_s.PWMSIG     : bus.PWMSIG;
        np = (i == 1) ? bus_s.NoPulse    : bus.NoPulse;
        if (Reset) begin
          open_f[i] = 1'b0;
          prev_c[i] = 1'b0;
        end else begin
          if (c && !prev_c[i]) begin
            if (open_f[i]) begin
              if (i == 0) q0.push_back(cur[i]);
              else        q1.push_back(cur[i]);
            end
            open_f[i] = 1'b1;
            cur[i]    = '{0, np, p, 1'b0};
            fell[i]   = 1'b0;
          end
          if (open_f[i]) begin
            if (p) begin
              if (fell[i]) cur[i].glitch = 1'b1;
              cur[i].w++;
            end else begin
              fell[i] = 1'b1;
            end
          end
          prev_c[i] = c;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11];
  int   base;

  initial begin
    // vecs[k] is input frame k. Its width is replayed in output frame k+1.
    vecs[0]  = '{100, 30, -1, 30, 1'b0};
    vecs[1]  = '{100, 30, -1, 30, 1'b0};
    vecs[2]  = '{100, 70, -1, 70, 1'b0};
    vecs[3]  = '{100,  5, -1,  5, 1'b0};
    vecs[4]  = '{100, 40, -1, 40, 1'b0};
    vecs[5]  = '{100, -1, -1, 40, 1'b1};
    vecs[6]  = '{100, 25, -1, 25, 1'b0};
    vecs[7]  = '{100, 20, 60, 20, 1'b0};
    vecs[8]  = '{100,  0, -1,  0, 1'b0};
    vecs[9]  = '{ 50, 49, -1, 49, 1'b0};
    vecs[10] = '{ 50, 49, -1, 49, 1'b0};

    set_in(1'b0, 1'b0);
    #2 Reset = 1'b1;
    repeat (3) @(posedge ClkFast);
    @(negedge ClkFast);
    chk("rst_pwm",  bus.PWMSIG,      0);
    chk("rst_clk",  bus.ClkSlowPWM,  0);
    chk("rst_np",   bus.NoPulse,     1);
    chk("rst_sat",  bus.Saturated,   0);
    chk("rst_sats", bus_s.Saturated, 0);
    @(posedge ClkFast); #1;
    Reset = 1'b0;

    for (int k = 0; k < 11; k++) run_frame(vecs[k].period, vecs[k].off1, vecs[k].off2);
    run_frame(100, -1, -1);
    run_frame(100, -1, -1);

    chk("nframes", q0.size() >= 12, 1);
    if (q0.size() >= 12) begin
      chk("first_w",  q0[0].w,  0);
      chk("first_np", q0[0].np, 1);
      for (int k = 0; k < 11; k++) begin
        chk($sformatf("w%0d", k),     q0[k+1].w,        vecs[k].exp_w);
        chk($sformatf("np%0d", k),    q0[k+1].np,       vecs[k].exp_np);
        chk($sformatf("align%0d", k), q0[k+1].first_hi, vecs[k].exp_w != 0);
        chk($sformatf("glitch%0d", k), q0[k+1].glitch,  0);
      end
    end
    chk("sat_main", bus.Saturated, 0);

    // Saturation with CNT_W=4: a reset first clears the sticky flag left over from the table.
    @(posedge ClkFast); #1;
    Reset = 1'b1;
    #2;
    chk("sat_clr", bus_s.Saturated, 0);
    @(posedge ClkFast); #1;
    Reset = 1'b0;
    @(negedge ClkFast);
    base = q1.size();
    run_frame(40, 30, -1);
    run_frame(40, 30, -1);
    run_frame(40, 30, -1);
    chk("sat_set",  bus_s.Saturated, 1);
    chk("sat_main2", bus.Saturated,  0);
    chk("sat_nfr", q1.size() >= base + 2, 1);
    if (q1.size() >= base + 2) begin
      chk("post_rst_w",  q1[base].w,    0);
      chk("post_rst_np", q1[base].np,   1);
      chk("sat_w",       q1[base+1].w,  15);
      chk("sat_np",      q1[base+1].np, 0);
    end

    // Mid-frame reset while the PWM output is high: the outputs must clear with no clock edge.
    for (int c = 0; c < 40; c++) begin
      @(posedge ClkFast); #1;
      set_in(c < 20, c == 30);
      if (c == 12) begin
        chk("pre_rst_pwm", bus_s.PWMSIG, 1);
        Reset = 1'b1;
        #1;
        chk("arst_pwm", bus_s.PWMSIG,     0);
        chk("arst_clk", bus_s.ClkSlowPWM, 0);
        chk("arst_np",  bus_s.NoPulse,    1);
        chk("arst_sat", bus_s.Saturated,  0);
      end
      if (c == 15) Reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ppm_to_pwm_converter.md
Name: ppm_to_pwm_converter

Overview:
- Receive-side counterpart of the PWM-to-PPM converter: rebuilds a PWM waveform from a PPM pulse train and its frame clock.
- Everything runs on ClkFast. For each frame it measures the PPM pulse position, counted in ClkFast cycles from the frame-clock rising edge.
- It replays that position as the PWM high time during the following frame, with a frame clock aligned to the output.

Parameters:
- CNT_W, 16, width of the position/width counters; the maximum measurable position is 2^CNT_W-1 cycles.

Ports:
- ClkFast  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- PPMSIG  input  1  PPM pulse train. It is asynchronous to ClkFast, and a rising edge marks the end of the PWM high time.
- ClkSlowPPM  input  1  frame clock accompanying PPMSIG. It is asynchronous, and its rising edge starts a frame.
- PWMSIG  output  1  regenerated PWM.
- ClkSlowPWM  output  1  frame clock aligned to PWMSIG.
- NoPulse  output  1  high for the current output frame if the measured frame contained no PPM pulse.
- Saturated  output  1  sticky; set when the position counter saturates; cleared only by Reset.

Behaviour:
- Reset (async): all synchronizers, counters and registers go to 0. Outputs while and after Reset: PWMSIG=0, ClkSlowPWM=0, NoPulse=1, Saturated=0.
- Synchronization: PPMSIG and ClkSlowPPM each pass through two flops, then a third delay flop for edge detection.
  - FrameEdge = clk_s2 & ~clk_s3.
  - PulseEdge = ppm_s2 & ~ppm_s3.
  - Each edge flag asserts 3 ClkFast cycles after the input edge and is high for exactly 1 cycle.
- Position counter (PosCnt, CNT_W bits):
  - On FrameEdge it loads 0; otherwise it increments.
  - At all-ones it holds (no wrap) and sets Saturated.
- Capture:
  - The first PulseEdge in a frame loads CapWidth <= PosCnt and sets Captured.
  - Later PulseEdges in the same frame are ignored.
- Frame turnover (on FrameEdge):
  - If Captured: OutWidth <= CapWidth and NoPulse <= 0.
  - Else: OutWidth keeps its previous value and NoPulse <= 1.
  - Captured clears.
- Simultaneous FrameEdge and PulseEdge in the same cycle:
  - Turnover uses the old Captured/CapWidth.
  - The pulse belongs to the new frame: CapWidth <= 0, Captured <= 1.
- PWM generation:
  - On FrameEdge: Remain <= new OutWidth, and PWMSIG <= (new OutWidth != 0).
  - Otherwise: if Remain != 0, Remain <= Remain-1; PWMSIG <= (Remain > 1).
  - PWMSIG is high for exactly OutWidth consecutive cycles, starting the cycle after FrameEdge.
  - Width 0 gives a PWMSIG that stays low for the whole frame.
  - If the next FrameEdge arrives before Remain reaches 0, the new width reloads immediately and PWMSIG stays high with no glitch (100% duty).
- ClkSlowPWM <= clk_s3 (registered). Its rising edge lands in the same cycle as the first PWMSIG high cycle.
- Latency: output frame N replays the pulse measured in input frame N-1, i.e. one frame plus 4 ClkFast cycles of pipeline.
- First frame after reset: OutWidth=0 and NoPulse=1 until a pulse has been captured.
- Reset mid-frame: immediate clear. The first FrameEdge after release starts a frame with PosCnt=0, and the next replay has width 0 / NoPulse=1.
- PWMSIG, ClkSlowPWM, NoPulse and Saturated are all driven directly from flops.

Test Plan:
- Reset then stimulus: frame period 100 cycles, PPM pulse 30 cycles after each frame edge → from the second frame on, PWMSIG is high for 30 cycles per frame, starting 4 cycles after the ClkSlowPPM rise and coincident with the ClkSlowPWM rise; NoPulse=0.
- Changing widths: pulse at 30, then 70, then 5 over successive frames → output widths 30, 70, 5, each one frame late, with no glitches between frames.
- Missing pulse: one frame without a PPM pulse after a frame at 40 → the next output frame repeats width 40 with NoPulse=1; NoPulse returns to 0 after the next frame with a pulse.
- Double pulse: pulses at 20 and 60 in one frame → output width 20.
- Edge coincidence: PPM pulse in the same synchronized cycle as the frame edge → the following output frame has width 0 (PWMSIG low) and NoPulse=0. Frame period 50 with pulse at 49 → width 49 with at most 1 low cycle per frame.
- Saturation with CNT_W=4: frame period 40, pulse at 30 → Saturated=1, captured width 15; Reset pulse mid-frame → all outputs clear asynchronously and Saturated=0.
